// File: rtl/taumin_stabilizer.sv
// taumin_stabilizer: range gate, 5-point running median and jump hysteresis
// on the YIN period estimate, holding the last trusted pitch through gaps.
module taumin_stabilizer #(
  parameter int unsigned WIDTH        = 11,
  parameter int unsigned TAU_LO       = 20,
  parameter int unsigned TAU_HI       = 2000,
  parameter int unsigned JUMP_TOL     = 8,
  parameter int unsigned JUMP_CONFIRM = 3,
  parameter int unsigned MISS_LIMIT   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] taumin_in,
  input  logic             taumin_valid_in,
  output logic [WIDTH-1:0] taumin_out,
  output logic             taumin_valid_out,
  output logic             locked_out
);

  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam int JW = $clog2(JUMP_CONFIRM + 1);
  localparam logic [WIDTH-1:0] LO_W = WIDTH'(TAU_LO);
  localparam logic [WIDTH-1:0] HI_W = WIDTH'(TAU_HI);
  localparam logic [WIDTH:0] TOL_W = (WIDTH + 1)'(JUMP_TOL);
  localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);
  localparam logic [MW-1:0] MISS_M1 = MW'(MISS_LIMIT - 1);
  localparam logic [JW-1:0] JC_M1 = JW'(JUMP_CONFIRM - 1);

  function automatic logic [WIDTH-1:0] vmin(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

  function automatic logic [WIDTH-1:0] vmax(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    return (a < b) ? b : a;
  endfunction

  logic [WIDTH-1:0] win [5];
  logic [2:0]       fill;
  logic [MW-1:0]    miss;
  logic             v0, v1, v2;
  logic [WIDTH-1:0] lo1, hi1, lo2, hi2, e1;
  logic [WIDTH-1:0] med;
  logic [JW-1:0]    jcnt;

  logic in_range, accept, reject, flush;
  logic [WIDTH-1:0] m_lo, m_hi, med_n;
  logic signed [WIDTH:0] diff;
  logic [WIDTH:0] adiff;

  always_comb begin
    in_range = (taumin_in >= LO_W) && (taumin_in <= HI_W);
    accept   = taumin_valid_in && in_range;
    reject   = taumin_valid_in && !in_range;
    flush    = reject && (miss >= MISS_M1);
  end

  // E0: gate, window shift, fill and miss tracking
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 5; i++) win[i] <= '0;
      fill <= '0;
      miss <= '0;
      v0   <= 1'b0;
    end else if (flush) begin
      fill <= '0;
      miss <= MISS_MAX;
      v0   <= 1'b0;
    end else if (accept) begin
      win[0] <= taumin_in;
      for (int i = 1; i < 5; i++) win[i] <= win[i-1];
      fill <= (fill == 3'd5) ? 3'd5 : fill + 3'd1;
      miss <= '0;
      v0   <= (fill >= 3'd4);
    end else begin
      v0 <= 1'b0;
      if (reject) miss <= miss + 1'b1;
    end
  end

  // E1: sort the two pairs; E2: median of the middle survivors and win[4]
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      {lo1, hi1, lo2, hi2, e1} <= '0;
      v1 <= 1'b0;
    end else begin
      lo1 <= vmin(win[0], win[1]);
      hi1 <= vmax(win[0], win[1]);
      lo2 <= vmin(win[2], win[3]);
      hi2 <= vmax(win[2], win[3]);
      e1  <= win[4];
      v1  <= v0 && !flush;
    end
  end

  always_comb begin
    m_lo  = vmax(lo1, lo2);
    m_hi  = vmin(hi1, hi2);
    med_n = vmax(vmin(m_lo, m_hi), vmin(vmax(m_lo, m_hi), e1));
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      med <= '0;
      v2  <= 1'b0;
    end else begin
      med <= med_n;
      v2  <= v1 && !flush;
    end
  end

  always_comb begin
    diff  = $signed({1'b0, med}) - $signed({1'b0, taumin_out});
    adiff = (diff < 0) ? $unsigned(-diff) : $unsigned(diff);
  end

  // E3: lock / tolerance / confirmed-jump decision
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      taumin_out       <= '0;
      taumin_valid_out <= 1'b0;
      locked_out       <= 1'b0;
      jcnt             <= '0;
    end else begin
      taumin_valid_out <= 1'b0;
      if (flush) begin
        locked_out <= 1'b0;
        jcnt       <= '0;
      end else if (v2) begin
        if (!locked_out || adiff <= TOL_W || jcnt == JC_M1) begin
          taumin_out       <= med;
          taumin_valid_out <= 1'b1;
          locked_out       <= 1'b1;
          jcnt             <= '0;
        end else begin
          jcnt <= jcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_taumin_stabilizer.sv
// tb_taumin_stabilizer: directed vectors for the taumin stabilizer.
// Monitor logs every output pulse with its edge index.
module tb_taumin_stabilizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] tau_in;
  logic        tau_vld;
  logic [10:0] tau_out;
  logic        tau_out_vld;
  logic        locked;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int in_cyc  = 0;
  int pulses  = 0;
  int pv[$];
  int pc[$];

  always #5 clk = ~clk;

  taumin_stabilizer dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .taumin_in       (tau_in),
    .taumin_valid_in (tau_vld),
    .taumin_out      (tau_out),
    .taumin_valid_out(tau_out_vld),
    .locked_out      (locked)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tau_out_vld === 1'b1) begin
      pulses++;
      pv.push_back(int'(tau_out));
      pc.push_back(cyc);
    end
  end

  task automatic check(string tag, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(int v);
    @(negedge clk);
    tau_in  = 11'(v);
    tau_vld = 1'b1;
    in_cyc  = cyc + 1;
    @(negedge clk);
    tau_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    tau_vld = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  int p0;
  int c5;

  initial begin
    rst_n   = 1'b0;
    tau_in  = '0;
    tau_vld = 1'b0;

    // reset with valid pulsing
    @(negedge clk);
    tau_in  = 11'd100;
    tau_vld = 1'b1;
    @(negedge clk);
    check("rst_hold0", {tau_out, tau_out_vld, locked}, 0);
    tau_in = 11'd200;
    @(negedge clk);
    check("rst_hold1", {tau_out, tau_out_vld, locked}, 0);
    tau_vld = 1'b0;
    rst_n   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_after", {tau_out, tau_out_vld, locked}, 0);
    end

    // median and lock
    p0 = pulses;
    push(100); idle(9);
    push(102); idle(9);
    push(500); idle(9);
    push(101); idle(9);
    check("med_nopulse", pulses, p0);
    push(99); idle(9);
    check("med_count", pulses, p0 + 1);
    check("med_val", pv.size() > 0 ? pv[$] : -1, 101);
    check("med_lat", pc.size() > 0 ? pc[$] : -1, in_cyc + 3);
    check("med_lock", locked, 1);

    // range gate and miss limit
    p0 = pulses;
    push(5);    idle(3);
    push(2047); idle(3);
    push(10);   idle(3);
    check("gate_lock3", locked, 1);
    push(2001);
    check("gate_unlock", locked, 0);
    idle(5);
    check("gate_nopulse", pulses, p0);
    check("gate_hold", tau_out, 101);
    for (int i = 0; i < 5; i++) begin
      push(250); idle(5);
    end
    check("relock_count", pulses, p0 + 1);
    check("relock_val", tau_out, 250);
    check("relock_lock", locked, 1);

    // jump confirm
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(100); idle(5);
    end
    check("jc_lock", tau_out, 100);
    p0 = pulses;
    push(300); idle(5);
    check("jc_p1", pulses, p0 + 1);
    check("jc_v1", tau_out, 100);
    push(300); idle(5);
    check("jc_p2", pulses, p0 + 2);
    check("jc_v2", tau_out, 100);
    push(300); idle(5);
    check("jc_p3", pulses, p0 + 2);
    push(300); idle(5);
    check("jc_p4", pulses, p0 + 2);
    check("jc_v4", tau_out, 100);
    push(300); idle(5);
    check("jc_p5", pulses, p0 + 3);
    check("jc_v5", tau_out, 300);

    // back-to-back
    do_reset();
    pv.delete();
    pc.delete();
    c5 = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      tau_in  = 11'(50 + 2 * i);
      tau_vld = 1'b1;
      if (i == 4) c5 = cyc + 1;
    end
    @(negedge clk);
    tau_vld = 1'b0;
    idle(8);
    check("b2b_count", pv.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("b2b_val", pv.size() > i ? pv[i] : -1, 54 + 2 * i);
      check("b2b_cyc", pc.size() > i ? pc[i] : -1, c5 + 3 + i);
    end

    // reset mid-pipeline
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 5; i++) push(100);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    check("mid_nopulse", pulses, p0);
    check("mid_outs", {tau_out, tau_out_vld, locked}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/taumin_stabilizer.md
# taumin_stabilizer

Conditions the raw YIN period estimate (`taumin`) before it reaches the bufferizer. It range-gates each estimate and takes a 5-point running median. A hysteresis stage rejects isolated octave jumps. The output is held through unvoiced gaps, so resynthesis never sees single-frame pitch glitches. It sits between `yin` and `bufferizer`, replacing the plain capture register on `taumin`.

## Interface
- `WIDTH`, 11: bit width of taumin in/out.
- `TAU_LO`, 20: smallest valid estimate; inputs below it are rejected.
- `TAU_HI`, 2000: largest valid estimate; inputs above it are rejected.
- `JUMP_TOL`, 8: largest |median − taumin_out| that is accepted immediately.
- `JUMP_CONFIRM`, 3: number of consecutive out-of-tolerance medians needed before a jump is accepted.
- `MISS_LIMIT`, 4: number of consecutive rejected inputs that forces an unlock and flush.

Ports:
- `clk_in`  in  1  system clock (100 MHz).
- `rst_in`  in  1  synchronous, active-low reset.
- `taumin_in`  in  WIDTH  raw estimate from yin.
- `taumin_valid_in`  in  1  single-cycle strobe; may assert every cycle.
- `taumin_out`  out  WIDTH  stabilized estimate; held between updates.
- `taumin_valid_out`  out  1  single-cycle strobe, high only on a cycle where `taumin_out` was (re)written.
- `locked_out`  out  1  high while the stage has a trusted pitch.

## Operation
- **Gate.** An input is accepted when `taumin_valid_in` is high and TAU_LO ≤ `taumin_in` ≤ TAU_HI. Otherwise the valid input is rejected.
- **Miss counter.**
  - Each rejected input increments the miss counter (saturating).
  - Any accepted input clears it.
  - When the counter reaches MISS_LIMIT, the block flushes:
    - window fill cleared to 0;
    - in-flight pipeline valids cleared;
    - jump counter cleared;
    - `locked_out` driven low.
  - `taumin_out` keeps its last value through the flush.
- **Window.**
  - 5-entry shift register of accepted inputs; newest enters, oldest leaves.
  - Fill count saturates at 5.
  - No median is produced until the fill count, including the current push, reaches 5.
- **Median.**
  - Exact median of the 5 window entries, taken after the push.
  - Uses a registered compare-exchange network; ties are resolved by value only.
- **Decision**, applied to each median M in order:
  - `locked_out` = 0: `taumin_out` ← M, valid pulse, `locked_out` ← 1, jump counter ← 0.
  - |M − `taumin_out`| ≤ JUMP_TOL: `taumin_out` ← M, valid pulse, jump counter ← 0.
  - Otherwise, if the jump counter = JUMP_CONFIRM−1: `taumin_out` ← M, valid pulse, jump counter ← 0.
  - Otherwise: jump counter + 1, no pulse, `taumin_out` unchanged.
- **Arithmetic.** The difference is computed in WIDTH+1 bits signed, then absolute value; no wrap.
- **Reset values.**
  - `taumin_out` = 0, `taumin_valid_out` = 0, `locked_out` = 0.
  - Window, fill count, miss counter, jump counter and pipeline valids = 0.

## Timing
- Fully pipelined; throughput is one input per cycle.
- The pipeline has four register edges:
  - E0: gate, window shift and fill update.
  - E1: sort stage 1.
  - E2: median register.
  - E3: decision, `taumin_out` and `taumin_valid_out`.
- Latency: `taumin_valid_in` sampled at edge N gives `taumin_valid_out` high in the cycle after edge N+3, i.e. 3 cycles of latency.
- The decision stage always compares against the current registered `taumin_out`. Back-to-back medians therefore see the result of the preceding decision.
- Flush on the MISS_LIMIT-th rejection takes effect at that edge. Medians still in flight are dropped, and no pulse is emitted for them.
- `rst_in` low at any edge clears all state at that edge; in-flight results are never emitted. The first accepted input after reset counts as fill 1.
- Simultaneous events: an input arriving at the same edge as a flush is discarded by the flush.

## Test plan
- **Reset.** Hold `rst_in` low for 2 cycles with `taumin_valid_in` pulsing → `taumin_out` = 0, `taumin_valid_out` = 0, `locked_out` = 0 throughout and for 3 cycles after release.
- **Median and lock.** Inputs 100, 102, 500, 101, 99, spaced 10 cycles apart → exactly one `taumin_valid_out`, 3 cycles after the 5th input, with `taumin_out` = 101 and `locked_out` = 1. No pulse after inputs 1–4.
- **Jump confirm.** Lock at 100 with five inputs of 100, then feed 300 ×5 →
  - pushes 1 and 2 pulse with value 100;
  - pushes 3 and 4 produce median 300 but no pulse;
  - push 5 pulses with `taumin_out` = 300.
- **Range gate and miss limit.** While locked at 101, feed 5, 2047, 10, 2001 → no pulses; `locked_out` falls at the edge of the 4th rejection; `taumin_out` stays 101. Then five inputs of 250 → a pulse with 250 and `locked_out` = 1, accepted unconditionally.
- **Back-to-back.** After reset, `taumin_valid_in` high for 7 consecutive cycles with 50, 52, 54, 56, 58, 60, 62 →
  - pulses on 3 consecutive cycles, starting 3 cycles after the 5th input;
  - values 54, 56, 58.
- **Reset mid-pipeline.** Five accepted inputs of 100, with `rst_in` low 1 cycle after the 5th → no `taumin_valid_out` ever; all outputs 0.
